// File: rtl/ex_muldiv_pkg.sv
// ex_muldiv_pkg: shared encodings for the EX-stage RV32M multiply/divide unit
package ex_muldiv_pkg;
  localparam logic [2:0] F3_MUL    = 3'b000;
  localparam logic [2:0] F3_MULH   = 3'b001;
  localparam logic [2:0] F3_MULHSU = 3'b010;
  localparam logic [2:0] F3_MULHU  = 3'b011;
  localparam logic [2:0] F3_DIV    = 3'b100;
  localparam logic [2:0] F3_DIVU   = 3'b101;
  localparam logic [2:0] F3_REM    = 3'b110;
  localparam logic [2:0] F3_REMU   = 3'b111;
  localparam int CTRL_MULDIV_BIT = 7;
  typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV, S_DONE} state_t;
endpackage

// File: rtl/ex_muldiv_if.sv
// ex_muldiv_if: EX-stage request/result bundle between pipeline and muldiv unit
interface ex_muldiv_if #(parameter int XLEN = 32);
  logic            start;
  logic [2:0]      funct3;
  logic [XLEN-1:0] op_a;
  logic [XLEN-1:0] op_b;
  logic            flush;
  logic            stall_req;
  logic            busy;
  logic            done;
  logic [XLEN-1:0] result;
  modport master (output start, funct3, op_a, op_b, flush, input stall_req, busy, done, result);
  modport slave (input start, funct3, op_a, op_b, flush, output stall_req, busy, done, result);
endinterface

// File: rtl/ex_div_iter.sv
// ex_div_iter: restoring divider on magnitudes; quo/rem show the value after the current step
module ex_div_iter #(parameter int W = 32) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic         en,
  input  logic [W-1:0] dividend,
  input  logic [W-1:0] divisor,
  output logic [W-1:0] quo,
  output logic [W-1:0] rem
);
  logic [W-1:0] r, q, d;
  logic [W:0]   sh, diff;
  always_comb begin
    sh   = {r, q[W-1]};
    diff = sh - {1'b0, d};
    quo  = {q[W-2:0], ~diff[W]};
    rem  = diff[W] ? sh[W-1:0] : diff[W-1:0];
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      r <= '0;
      q <= '0;
      d <= '0;
    end else if (load) begin
      r <= '0;
      q <= dividend;
      d <= divisor;
    end else if (en) begin
      r <= rem;
      q <= quo;
    end
  end
endmodule

// File: rtl/ex_muldiv.sv
// ex_muldiv: iterative RV32M multiply/divide in EX, stalling the pipeline until done
module ex_muldiv
  import ex_muldiv_pkg::*;
#(
  parameter int XLEN = 32,
  parameter int ITER = 32
) (
  input logic        clk,
  input logic        rst,
  ex_muldiv_if.slave bus
);
  localparam int CW = $clog2(ITER) + 1;
  state_t st, st_n;
  logic [2:0] f3;
  logic neg_a, neg_b;
  logic [XLEN-1:0] mag_a;
  logic [2*XLEN-1:0] p, p_n, p_fix;
  logic [CW-1:0] cnt;
  logic sa, sb, na, nb, dz, ovf, special, accept, last, run;
  logic [XLEN-1:0] ma, mb, spec_res, q, r, q_fix, r_fix, fin;
  logic [XLEN:0] sum;
  assign sa       = bus.funct3[2] ? ~bus.funct3[0] : (bus.funct3[1:0] != 2'b11);
  assign sb       = bus.funct3[2] ? ~bus.funct3[0] : ~bus.funct3[1];
  assign na       = sa & bus.op_a[XLEN-1];
  assign nb       = sb & bus.op_b[XLEN-1];
  assign ma       = na ? -bus.op_a : bus.op_a;
  assign mb       = nb ? -bus.op_b : bus.op_b;
  assign dz       = bus.op_b == '0;
  assign ovf      = ~bus.funct3[0] & (bus.op_a == {1'b1, {(XLEN-1){1'b0}}}) & (&bus.op_b);
  assign special  = bus.funct3[2] & (dz | ovf);
  assign spec_res = bus.funct3[1] ? (dz ? bus.op_a : '0) : (dz ? '1 : {1'b1, {(XLEN-1){1'b0}}});
  assign accept   = (st == S_IDLE) & bus.start & ~bus.flush;
  assign run      = (st == S_MUL) | (st == S_DIV);
  assign last     = cnt == CW'(ITER - 1);
  // Right-shifting shift-add: the multiplier drains out of the low half as the product fills in.
  assign sum      = {1'b0, p[2*XLEN-1:XLEN]} + (p[0] ? {1'b0, mag_a} : '0);
  assign p_n      = {sum, p[XLEN-1:1]};
  assign p_fix    = (neg_a ^ neg_b) ? -p_n : p_n;
  assign q_fix    = (neg_a ^ neg_b) ? -q : q;
  assign r_fix    = neg_a ? -r : r;
  assign fin      = (st == S_IDLE) ? spec_res :
                    (st == S_MUL) ? ((f3 == F3_MUL) ? p_fix[XLEN-1:0] : p_fix[2*XLEN-1:XLEN]) :
                    (f3[1] ? r_fix : q_fix);
  ex_div_iter #(.W(XLEN)) u_div (
    .clk(clk), .rst(rst), .load(accept), .en(st == S_DIV),
    .dividend(ma), .divisor(mb), .quo(q), .rem(r)
  );
  always_comb begin
    st_n          = st;
    bus.busy      = run;
    bus.done      = st == S_DONE;
    bus.stall_req = accept | run;
    if (bus.flush) st_n = S_IDLE;
    else if (accept) st_n = !bus.funct3[2] ? S_MUL : special ? S_DONE : S_DIV;
    else if (run && last) st_n = S_DONE;
    else if (st == S_DONE) st_n = S_IDLE;
  end
  always_ff @(posedge clk) begin
    if (rst) st <= S_IDLE;
    else st <= st_n;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      f3         <= '0;
      neg_a      <= 1'b0;
      neg_b      <= 1'b0;
      mag_a      <= '0;
      p          <= '0;
      cnt        <= '0;
      bus.result <= '0;
    end else begin
      if (accept) begin
        f3    <= bus.funct3;
        neg_a <= na;
        neg_b <= nb;
        mag_a <= ma;
        p     <= {{XLEN{1'b0}}, mb};
        cnt   <= '0;
      end else if (run) begin
        cnt <= cnt + 1'b1;
        if (st == S_MUL) p <= p_n;
      end
      if (st_n == S_DONE) bus.result <= fin;
    end
  end
endmodule

// File: tb/tb_ex_muldiv.sv
// tb_ex_muldiv: directed and randomized checks of ex_muldiv against an arithmetic reference
module tb_ex_muldiv;
  import ex_muldiv_pkg::*;
  logic clk = 0;
  logic rst;
  int checks = 0;
  int failures = 0;
  logic [31:0] last_exp = '0;
  ex_muldiv_if bus ();
  ex_muldiv dut (.clk(clk), .rst(rst), .bus(bus));
  always #5 clk = ~clk;

  logic [2:0]  tf [12] = '{F3_MUL, F3_MULH, F3_MULHU, F3_MULHSU, F3_DIV, F3_REM,
                           F3_DIVU, F3_REMU, F3_DIVU, F3_REM, F3_DIV, F3_REM};
  logic [31:0] ta [12] = '{32'd7, 32'h80000000, 32'h80000000, 32'hffffffff, 32'hfffffff9, 32'hfffffff9,
                           32'd100, 32'd100, 32'd55, 32'h1234, 32'h80000000, 32'h80000000};
  logic [31:0] tb_v [12] = '{32'hfffffffd, 32'h80000000, 32'h80000000, 32'd2, 32'd2, 32'd2,
                             32'd7, 32'd7, 32'd0, 32'd0, 32'hffffffff, 32'hffffffff};
  logic [31:0] te [12] = '{32'hffffffeb, 32'h40000000, 32'h40000000, 32'hffffffff, 32'hfffffffd, 32'hffffffff,
                           32'd14, 32'd2, 32'hffffffff, 32'h1234, 32'h80000000, 32'd0};
  int tl [12] = '{33, 33, 33, 33, 33, 33, 33, 33, 1, 1, 1, 1};

  function automatic logic [31:0] model(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
    longint sa, sb, ub;
    logic [63:0] pr;
    int ia, ib;
    sa = longint'(signed'(a));
    sb = longint'(signed'(b));
    ub = longint'(b);
    ia = signed'(a);
    ib = signed'(b);
    pr = '0;
    case (f)
      F3_MUL, F3_MULH: pr = sa * sb;
      F3_MULHSU:       pr = sa * ub;
      F3_MULHU:        pr = {32'b0, a} * {32'b0, b};
      default:         pr = '0;
    endcase
    if (!f[2]) return (f == F3_MUL) ? pr[31:0] : pr[63:32];
    if (b == 0) return f[1] ? a : 32'hffffffff;
    if (!f[0] && a == 32'h80000000 && b == 32'hffffffff) return f[1] ? 32'd0 : 32'h80000000;
    case (f)
      F3_DIV:  return 32'(ia / ib);
      F3_REM:  return 32'(ia % ib);
      F3_DIVU: return a / b;
      default: return a % b;
    endcase
  endfunction

  function automatic int model_lat(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
    return (f[2] && (b == 0 || (!f[0] && a == 32'h80000000 && b == 32'hffffffff))) ? 1 : 33;
  endfunction

  task automatic next_cycle;
    @(posedge clk);
    #1;
  endtask

  // Accepts one op in the current IDLE cycle and returns in its done cycle (or at the cycle budget).
  task automatic do_op(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b,
                       output logic [31:0] res, output int lat, output bit st_ok);
    bus.start = 1;
    bus.funct3 = f;
    bus.op_a = a;
    bus.op_b = b;
    #1;
    st_ok = (bus.stall_req === 1'b1);
    next_cycle();
    bus.start = 0;
    bus.op_a = $urandom;
    bus.op_b = $urandom;
    bus.funct3 = 3'($urandom);
    lat = 1;
    while (bus.done !== 1'b1 && lat < 100) begin
      if (bus.stall_req !== 1'b1 || bus.busy !== 1'b1) st_ok = 0;
      next_cycle();
      lat++;
    end
    if (bus.stall_req !== 1'b0 || bus.busy !== 1'b0) st_ok = 0;
    res = bus.result;
  endtask

  task automatic test_reset;
    rst = 1;
    next_cycle();
    next_cycle();
    rst = 0;
    checks++;
    if (bus.result !== 32'd0) begin failures++; $display("FAIL reset_result actual=%h expected=0", bus.result); end
    checks++;
    if (bus.done !== 1'b0 || bus.busy !== 1'b0 || bus.stall_req !== 1'b0) begin
      failures++;
      $display("FAIL reset_flags done=%b busy=%b stall_req=%b expected 0/0/0", bus.done, bus.busy, bus.stall_req);
    end
  endtask

  task automatic test_directed;
    logic [31:0] res;
    int lat;
    bit st_ok;
    for (int i = 0; i < 12; i++) begin
      do_op(tf[i], ta[i], tb_v[i], res, lat, st_ok);
      checks++;
      if (res !== te[i]) begin failures++; $display("FAIL directed_result[%0d] actual=%h expected=%h", i, res, te[i]); end
      checks++;
      if (lat !== tl[i]) begin failures++; $display("FAIL directed_latency[%0d] actual=%0d expected=%0d", i, lat, tl[i]); end
      checks++;
      if (!st_ok) begin failures++; $display("FAIL directed_stall[%0d] actual=0 expected=1 (stall_req/busy profile)", i); end
      last_exp = te[i];
      next_cycle();
      checks++;
      if (bus.done !== 1'b0) begin failures++; $display("FAIL directed_done_pulse[%0d] actual=%b expected=0", i, bus.done); end
    end
  endtask

  task automatic test_random;
    logic [31:0] res, a, b, e;
    logic [2:0] f;
    int lat, el;
    bit st_ok;
    for (int i = 0; i < 60; i++) begin
      f = 3'($urandom_range(0, 7));
      a = $urandom;
      b = $urandom;
      case ($urandom_range(0, 7))
        0: b = 0;
        1: begin a = 32'h80000000; b = 32'hffffffff; end
        2: b = $urandom_range(1, 15);
        3: b = -$urandom_range(1, 15);
        default: ;
      endcase
      e = model(f, a, b);
      el = model_lat(f, a, b);
      do_op(f, a, b, res, lat, st_ok);
      checks++;
      if (res !== e) begin failures++; $display("FAIL random_result f3=%0d a=%h b=%h actual=%h expected=%h", f, a, b, res, e); end
      checks++;
      if (lat !== el) begin failures++; $display("FAIL random_latency f3=%0d b=%h actual=%0d expected=%0d", f, b, lat, el); end
      checks++;
      if (!st_ok) begin failures++; $display("FAIL random_stall f3=%0d actual=0 expected=1", f); end
      last_exp = e;
      next_cycle();
    end
  endtask

  task automatic test_back_to_back;
    logic [31:0] res, a, b, e;
    int lat;
    bit st_ok;
    a = $urandom;
    b = $urandom;
    do_op(F3_MULHU, a, b, res, lat, st_ok);
    e = model(F3_MULHU, a, b);
    checks++;
    if (res !== e) begin failures++; $display("FAIL b2b_first actual=%h expected=%h", res, e); end
    a = $urandom;
    b = $urandom_range(1, 1000);
    bus.start = 1;
    bus.funct3 = F3_DIVU;
    bus.op_a = a;
    bus.op_b = b;
    #1;
    checks++;
    if (bus.stall_req !== 1'b0) begin failures++; $display("FAIL b2b_done_no_accept stall_req actual=%b expected=0", bus.stall_req); end
    next_cycle();
    do_op(F3_DIVU, a, b, res, lat, st_ok);
    checks++;
    if (res !== a / b) begin failures++; $display("FAIL b2b_second actual=%h expected=%h", res, a / b); end
    checks++;
    if (lat !== 33) begin failures++; $display("FAIL b2b_latency actual=%0d expected=33", lat); end
    last_exp = a / b;
    next_cycle();
  endtask

  task automatic test_flush;
    logic [31:0] res;
    int lat, seen;
    bit st_ok;
    bus.start = 1;
    bus.funct3 = F3_DIV;
    bus.op_a = 32'h0badf00d;
    bus.op_b = 32'd37;
    next_cycle();
    bus.start = 0;
    repeat (9) next_cycle();
    bus.flush = 1;
    next_cycle();
    bus.flush = 0;
    #1;
    checks++;
    if (bus.busy !== 1'b0 || bus.stall_req !== 1'b0 || bus.done !== 1'b0) begin
      failures++;
      $display("FAIL flush_idle busy=%b stall_req=%b done=%b expected 0/0/0", bus.busy, bus.stall_req, bus.done);
    end
    checks++;
    if (bus.result !== last_exp) begin failures++; $display("FAIL flush_result_held actual=%h expected=%h", bus.result, last_exp); end
    bus.start = 1;
    bus.flush = 1;
    bus.funct3 = F3_MUL;
    #1;
    checks++;
    if (bus.stall_req !== 1'b0) begin failures++; $display("FAIL flush_beats_start stall_req actual=%b expected=0", bus.stall_req); end
    next_cycle();
    bus.start = 0;
    bus.flush = 0;
    seen = 0;
    for (int i = 0; i < 40; i++) begin
      if (bus.done === 1'b1 || bus.busy === 1'b1) seen++;
      next_cycle();
    end
    checks++;
    if (seen !== 0) begin failures++; $display("FAIL flush_no_done actual_active_cycles=%0d expected=0", seen); end
    do_op(F3_MUL, 32'd3, 32'd5, res, lat, st_ok);
    checks++;
    if (res !== 32'd15) begin failures++; $display("FAIL flush_then_mul actual=%h expected=f", res); end
    checks++;
    if (lat !== 33) begin failures++; $display("FAIL flush_then_mul_latency actual=%0d expected=33", lat); end
    last_exp = 32'd15;
    next_cycle();
  endtask

  task automatic test_rst_mid;
    int seen;
    bus.start = 1;
    bus.funct3 = F3_MUL;
    bus.op_a = $urandom;
    bus.op_b = $urandom;
    next_cycle();
    bus.start = 0;
    repeat (5) next_cycle();
    rst = 1;
    next_cycle();
    rst = 0;
    checks++;
    if (bus.result !== 32'd0) begin failures++; $display("FAIL rst_mid_result actual=%h expected=0", bus.result); end
    checks++;
    if (bus.done !== 1'b0 || bus.busy !== 1'b0) begin failures++; $display("FAIL rst_mid_flags done=%b busy=%b expected 0/0", bus.done, bus.busy); end
    seen = 0;
    for (int i = 0; i < 40; i++) begin
      if (bus.done === 1'b1) seen++;
      next_cycle();
    end
    checks++;
    if (seen !== 0) begin failures++; $display("FAIL rst_mid_no_done actual=%0d expected=0", seen); end
    last_exp = 32'd0;
  endtask

  initial begin
    rst = 1;
    bus.start = 0;
    bus.flush = 0;
    bus.funct3 = 3'd0;
    bus.op_a = '0;
    bus.op_b = '0;
    test_reset();
    test_directed();
    test_back_to_back();
    test_flush();
    test_rst_mid();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/ex_muldiv.md
Name: ex_muldiv

Overview:
- Iterative RV32M multiply/divide unit in the EX stage, directly downstream of the ID/EX pipeline register.
- Consumes the decoded M-extension operation (funct3) and forwarded rs1/rs2 operands, and computes the result over multiple cycles.
- Holds the pipeline through a stall request until the result is ready.
- Result is muxed into the EX result path alongside the ALU.

Parameters:
- XLEN, 32: operand/result width; only 32 is supported.
- ITER, 32: iterations per MUL/DIV operation; must equal XLEN.

Ports:
- clk  in  1  pipeline clock
- rst  in  1  synchronous, active-high reset
- start  in  1  EX holds a valid M-ext instruction (ctrl muldiv bit set, not squashed)
- funct3  in  3  M-ext opcode select from the ID/EX register
- op_a  in  32  rs1 operand, after forwarding
- op_b  in  32  rs2 operand, after forwarding
- flush  in  1  branch kill of the EX instruction; aborts the operation
- stall_req  out  1  freeze PC, IF/ID and ID/EX while high
- busy  out  1  state is MUL or DIV
- done  out  1  result valid; one-cycle pulse
- result  out  32  final rd value; stable from done until the next accept

Behaviour:
- Reset (rst=1 at posedge): state=IDLE, result=0, done=0, busy=0, all internal regs cleared. Reset mid-operation has the same effect; no done is produced.
- States: IDLE, MUL, DIV, DONE.
- IDLE with start=1, flush=0: latch funct3, op_a, op_b.
  - funct3[2]=0: go to MUL.
  - funct3[2]=1 with divisor=0 or signed overflow: go directly to DONE.
  - Otherwise: go to DIV.
  - The iteration counter loads 0.
- Operand changes after acceptance are ignored.
- MUL:
  - Shift-add on the magnitudes (unsigned 32x32 to 64), one bit per cycle.
  - After ITER cycles, go to DONE.
  - Sign handling: MUL and MULH treat both operands as signed; MULHSU treats a as signed, b as unsigned; MULHU treats both as unsigned.
  - Negate the 64-bit product when the operand signs differ.
  - MUL returns product[31:0]; MULH, MULHSU and MULHU return product[63:32].
- DIV:
  - Restoring division on the magnitudes, one quotient bit per cycle; ITER cycles, then DONE.
  - DIV and REM are signed; DIVU and REMU are unsigned.
  - Quotient is negated if the operand signs differ.
  - Remainder takes the sign of the dividend.
- Special cases, applied with no iteration:
  - Divide by zero: DIV/DIVU return 0xFFFFFFFF; REM/REMU return op_a.
  - Signed overflow (0x80000000 / 0xFFFFFFFF): DIV returns 0x80000000; REM returns 0.
- DONE:
  - done=1 and result updated; unconditionally return to IDLE next cycle.
  - The block does not re-accept in DONE, even if start=1.
- stall_req = (IDLE & start & ~flush) | busy. It is 0 in DONE so the pipeline advances on the done cycle.
- Latency (accept at cycle N):
  - Iterative op: done at cycle N+ITER+1 (N+33).
  - Special case: done at cycle N+1.
- Back-to-back M-ops: the next op is accepted in the IDLE cycle after DONE.
- flush=1 in any state: go to IDLE next cycle, done stays 0, result is held.
- If flush and start are both high in IDLE, flush wins and nothing is accepted.
- Width rules:
  - 64-bit product accumulator.
  - 33-bit partial remainder (sign bit for the restore test).
  - Counter is $clog2(ITER)+1 bits wide.

Decomposition:
- Shared package/header holds:
  - funct3 encodings: MUL=000, MULH=001, MULHSU=010, MULHU=011, DIV=100, DIVU=101, REM=110, REMU=111.
  - FSM state encodings.
  - The ctrl-bus index of the muldiv enable bit.
- One natural sub-module: ex_div_iter, the restoring-divider datapath (remainder/quotient shift registers, one step per enable).
- Sign fix-up and the multiplier stay in ex_muldiv.

Test Plan:
- MUL op_a=7, op_b=0xFFFFFFFD, accept at cycle 0 -> stall_req high cycles 0-32; done at cycle 33; result=0xFFFFFFEB.
- MULH op_a=op_b=0x80000000 -> result=0x40000000. MULHU with the same operands -> 0x40000000. MULHSU op_a=0xFFFFFFFF, op_b=2 -> 0xFFFFFFFF.
- DIV op_a=0xFFFFFFF9 (-7), op_b=2 -> result=0xFFFFFFFD. REM with the same operands -> 0xFFFFFFFF. DIVU 100/7 -> 14. REMU 100/7 -> 2.
- DIVU op_b=0 -> done 1 cycle after accept, result=0xFFFFFFFF. REM op_a=0x1234, op_b=0 -> 0x1234. DIV 0x80000000/0xFFFFFFFF -> 0x80000000, done after 1 cycle.
- Abort cases:
  - Flush at iteration 10 of a DIV -> IDLE next cycle; stall_req and busy drop; no done; a following MUL 3*5 -> 15 at +33 cycles.
  - rst asserted mid-MUL -> next cycle result=0, done=0, busy=0.
